// File: rtl/lsu_bus_pkg.sv
// lsu_bus shared types: mem_op encodings, FSM states
// and the access legality rule.
package lsu_bus_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic access_legal(
    input logic       write,
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (op)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = !off[0];
      MEM_W:         ok = (off == 2'b00);
      default:       ok = 1'b0;
    endcase
    // unsigned variants have no store form
    return ok && !(write && op[2]);
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Data-memory bus: request channel plus response channel.
// master = LSU side, slave = memory side.
interface lsu_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_resp_valid;
  logic              bus_resp_ready;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req_valid, bus_write, bus_addr,
    output bus_wdata, bus_wstrb, bus_resp_ready,
    input  bus_req_ready, bus_resp_valid,
    input  bus_rdata, bus_err
  );

  modport slave (
    input  bus_req_valid, bus_write, bus_addr,
    input  bus_wdata, bus_wstrb, bus_resp_ready,
    output bus_req_ready, bus_resp_valid,
    output bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_bus_align.sv
// lsu_align: store lane replicate/strobe and
// load byte/half extract with sign/zero extension.
module lsu_align
  import lsu_bus_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);
  logic [31:0] ld_shift;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        sx;

  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b0000;
    if (write) begin
      unique case (1'b1)
        (op[1:0] == 2'b00): begin
          st_wdata = {4{st_data[7:0]}};
          st_wstrb = 4'b0001 << off;
        end
        (op[1:0] == 2'b01): begin
          st_wdata = {2{st_data[15:0]}};
          st_wstrb = 4'b0011 << off;
        end
        default: begin
          st_wdata = st_data;
          st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign ld_shift = ld_word >> {off, 3'b000};
  assign ld_b     = ld_shift[7:0];
  assign ld_h     = off[1] ? ld_word[31:16]
                           : ld_word[15:0];
  assign sx       = !op[2];

  always_comb begin
    ld_data = ld_word;
    unique case (1'b1)
      (op[1:0] == 2'b00):
        ld_data = {{24{sx & ld_b[7]}}, ld_b};
      (op[1:0] == 2'b01):
        ld_data = {{16{sx & ld_h[15]}}, ld_h};
      default:
        ld_data = ld_word;
    endcase
  end
endmodule

// File: rtl/lsu_bus.sv
// lsu_bus: one core memory access per request over a
// valid/ready data bus, IDLE -> REQ -> WAIT -> RESP.
module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  lsu_bus_if.master         bus
);
  state_e            state_q, state_d;
  logic              write_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              legal;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_data;

  assign legal = access_legal(req_write, req_op,
                              req_addr[1:0]);

  lsu_align u_align (
    .write    (write_q),
    .op       (op_q),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .st_wdata (st_wdata),
    .st_wstrb (st_wstrb),
    .ld_word  (bus.bus_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (req_valid)
          state_d = legal ? ST_REQ : ST_RESP;
      ST_REQ:
        if (bus.bus_req_ready) state_d = ST_WAIT;
      ST_WAIT:
        if (bus.bus_resp_valid) state_d = ST_RESP;
      ST_RESP:
        if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        write_q <= req_write;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= !legal;
      end
      // stores and bus errors return zero data
      if (state_q == ST_WAIT && bus.bus_resp_valid) begin
        rdata_q <= (bus.bus_err || write_q) ? '0
                                            : ld_data;
        err_q   <= bus.bus_err;
      end
    end
  end

  always_comb begin
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    resp_rdata         = '0;
    resp_err           = 1'b0;
    bus.bus_req_valid  = 1'b0;
    bus.bus_write      = 1'b0;
    bus.bus_addr       = '0;
    bus.bus_wdata      = '0;
    bus.bus_wstrb      = 4'b0000;
    bus.bus_resp_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_REQ: begin
        bus.bus_req_valid = 1'b1;
        bus.bus_write     = write_q;
        bus.bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        bus.bus_wdata     = st_wdata;
        bus.bus_wstrb     = st_wstrb;
      end
      ST_WAIT: bus.bus_resp_ready = 1'b1;
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: req_ready = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_lsu_bus.sv
// tb_lsu_bus: directed accesses checked every cycle
// against a behavioural access model plus literal pins.
module tb_lsu_bus;
  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_RESP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_bus_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  lsu_bus #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ph = P_IDLE;
  bit cmp_en = 1'b0;
  int bus_cycles = 0;

  logic        m_w;
  logic [31:0] m_addr;
  logic [3:0]  m_strb;
  logic [31:0] m_wdat;
  logic [31:0] m_rdat;
  logic        m_err;
  logic        m_legal;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_rdata;
  logic        cap_err;
  bit          saw_bus;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // What one access must produce, from the access rules.
  task automatic model(
    input  logic        w,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  logic        be,
    output logic        legal,
    output logic [3:0]  strb,
    output logic [31:0] wdat,
    output logic [31:0] rdat,
    output logic        err
  );
    int sz;
    int off;
    bit [31:0] mask;
    bit [31:0] v;
    off = int'(a[1:0]);
    sz = (op[1:0] == 2'd0) ? 1 :
         (op[1:0] == 2'd1) ? 2 : 4;
    legal = (op inside {3'b000, 3'b001, 3'b010,
                        3'b100, 3'b101})
            && !(w && op[2]) && (a % sz == 0);
    strb = w ? 4'(((1 << sz) - 1) << off) : 4'b0;
    wdat = (sz == 1) ? (wd & 32'hff) * 32'h01010101 :
           (sz == 2) ? (wd & 32'hffff) * 32'h00010001 :
           wd;
    mask = (sz == 4) ? 32'hffff_ffff
                     : (32'h1 << (8 * sz)) - 1;
    v = (rd >> (8 * off)) & mask;
    if (!op[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    if (!legal) begin
      rdat = 32'h0; err = 1'b1;
    end else if (w || be) begin
      rdat = 32'h0; err = be;
    end else begin
      rdat = v; err = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready),
          32'(ph == P_IDLE));
      chk("bus_req_valid", 32'(bif.bus_req_valid),
          32'(ph == P_REQ));
      chk("bus_resp_ready", 32'(bif.bus_resp_ready),
          32'(ph == P_WAIT));
      chk("resp_valid", 32'(resp_valid),
          32'(ph == P_RESP));
      if (ph == P_REQ && bif.bus_req_valid) begin
        bus_cycles++;
        cap_addr  = bif.bus_addr;
        cap_wdata = bif.bus_wdata;
        cap_wstrb = bif.bus_wstrb;
        chk("bus_addr", bif.bus_addr,
            m_addr & 32'hffff_fffc);
        chk("bus_write", 32'(bif.bus_write), 32'(m_w));
        chk("bus_wstrb", 32'(bif.bus_wstrb),
            32'(m_strb));
        if (m_w) chk("bus_wdata", bif.bus_wdata, m_wdat);
      end
      if (ph == P_RESP && resp_valid) begin
        cap_rdata = resp_rdata;
        cap_err   = resp_err;
        chk("resp_rdata", resp_rdata, m_rdat);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
  end

  task automatic run(
    input logic        w,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input logic        be,
    input int          rdy_dly,
    input int          rsp_dly,
    input logic        junk
  );
    int n0;
    model(w, op, a, wd, rd, be,
          m_legal, m_strb, m_wdat, m_rdat, m_err);
    m_w = w;
    m_addr = a;
    n0 = bus_cycles;
    cap_rdata = 32'hdead_beef;
    cap_err = 1'bx;
    req_valid = 1'b1;
    req_write = w;
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 32'h5555_5555;
    if (m_legal) begin
      ph = P_REQ;
      repeat (rdy_dly) begin @(posedge clk); #1; end
      bif.bus_req_ready = 1'b1;
      if (junk) begin
        bif.bus_resp_valid = 1'b1;
        bif.bus_rdata = ~rd;
        bif.bus_err = 1'b1;
      end
      @(posedge clk); #1;
      bif.bus_req_ready = 1'b0;
      ph = P_WAIT;
      bif.bus_resp_valid = 1'b1;
      bif.bus_rdata = rd;
      bif.bus_err = be;
      @(posedge clk); #1;
      bif.bus_resp_valid = 1'b0;
      bif.bus_rdata = 32'h0;
      bif.bus_err = 1'b0;
    end
    ph = P_RESP;
    repeat (rsp_dly) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    ph = P_IDLE;
    saw_bus = (bus_cycles != n0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_op = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    resp_ready = 1'b0;
    bif.bus_req_ready = 1'b0;
    bif.bus_resp_valid = 1'b0;
    bif.bus_rdata = 32'h0;
    bif.bus_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst bus_req_valid",
        32'(bif.bus_req_valid), 32'd0);
    chk("rst bus_wstrb", 32'(bif.bus_wstrb), 32'd0);
    chk("rst bus_resp_ready",
        32'(bif.bus_resp_ready), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // sb to the top byte lane
    run(1, 3'b000, 32'h8000_0003, 32'h0000_00ab,
        32'h0, 0, 0, 0, 0);
    chk("sb wstrb", 32'(cap_wstrb), 32'h8);
    chk("sb wdata", cap_wdata, 32'habab_abab);
    chk("sb addr", cap_addr, 32'h8000_0000);
    chk("sb err", 32'(cap_err), 32'd0);

    run(0, 3'b001, 32'h2000_0002, 32'h0,
        32'h8001_1234, 0, 0, 0, 0);
    chk("lh rdata", cap_rdata, 32'hffff_8001);
    run(0, 3'b101, 32'h2000_0002, 32'h0,
        32'h8001_1234, 0, 0, 0, 0);
    chk("lhu rdata", cap_rdata, 32'h0000_8001);

    // misaligned word: no bus traffic
    run(0, 3'b010, 32'h2000_0002, 32'h0,
        32'h1234_5678, 0, 0, 0, 0);
    chk("lw mis bus", 32'(saw_bus), 32'd0);
    chk("lw mis err", 32'(cap_err), 32'd1);
    chk("lw mis rdata", cap_rdata, 32'd0);

    run(0, 3'b000, 32'h3000_0001, 32'h0,
        32'h0000_7f00, 0, 3, 2, 0);
    chk("lb stall rdata", cap_rdata, 32'h0000_007f);

    run(0, 3'b010, 32'h4000_0008, 32'h0,
        32'hcafe_f00d, 1, 0, 0, 0);
    chk("lw buserr err", 32'(cap_err), 32'd1);
    chk("lw buserr rdata", cap_rdata, 32'd0);
    run(1, 3'b010, 32'h4000_000c, 32'h1122_3344,
        32'h0, 0, 1, 0, 0);
    chk("sw wstrb", 32'(cap_wstrb), 32'hf);
    chk("sw wdata", cap_wdata, 32'h1122_3344);
    chk("sw err", 32'(cap_err), 32'd0);

    run(1, 3'b001, 32'h5000_0002, 32'h1234_abcd,
        32'h0, 0, 0, 0, 0);
    chk("sh wstrb", 32'(cap_wstrb), 32'hc);
    chk("sh wdata", cap_wdata, 32'habcd_abcd);

    // store with an unsigned op, reserved load op
    run(1, 3'b100, 32'h5000_0000, 32'h55,
        32'h0, 0, 0, 0, 0);
    chk("sbu err", 32'(cap_err), 32'd1);
    chk("sbu bus", 32'(saw_bus), 32'd0);
    run(0, 3'b011, 32'h5000_0000, 32'h0,
        32'h0, 0, 0, 1, 0);
    chk("op011 err", 32'(cap_err), 32'd1);
    run(0, 3'b110, 32'h5000_0000, 32'h0,
        32'h0, 0, 0, 0, 0);
    chk("op110 err", 32'(cap_err), 32'd1);

    // early response during REQ handshake is ignored
    run(0, 3'b000, 32'h6000_0002, 32'h0,
        32'h0080_0000, 0, 0, 0, 1);
    chk("lb early rdata", cap_rdata, 32'hffff_ff80);
    chk("lb early err", 32'(cap_err), 32'd0);

    // reset while waiting for the bus response
    model(0, 3'b010, 32'h7000_0000, 32'h0, 32'h0, 0,
          m_legal, m_strb, m_wdat, m_rdat, m_err);
    m_w = 1'b0;
    m_addr = 32'h7000_0000;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_op = 3'b010;
    req_addr = 32'h7000_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ph = P_REQ;
    bif.bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bif.bus_req_ready = 1'b0;
    ph = P_WAIT;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ph = P_IDLE;
    chk("wrst req_ready", 32'(req_ready), 32'd1);
    chk("wrst resp_valid", 32'(resp_valid), 32'd0);
    chk("wrst bus_req_valid",
        32'(bif.bus_req_valid), 32'd0);
    chk("wrst bus_resp_ready",
        32'(bif.bus_resp_ready), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    run(0, 3'b100, 32'h7000_0003, 32'h0,
        32'h9900_0000, 0, 0, 0, 0);
    chk("lbu rdata", cap_rdata, 32'h0000_0099);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_bus.md
Name: lsu_bus

Overview:
- Load/store unit that executes one memory access per request, driven by the decoder's mem_write / mem_op fields.
- Accepts a request from the core, aligns store data and byte strobes onto a 32-bit bus, and waits for the bus response.
- Returns sign- or zero-extended load data, or an error flag.
- Sits between the core execute stage and the data-memory bus, replacing the single-cycle combinational memory path for the multi-cycle core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1=store, 0=load (decoder mem_write)
- req_op  in  3  000 b-signed, 001 h-signed, 010 w, 100 bu, 101 hu (decoder mem_op)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  result available
- resp_ready  in  1  core consumes result
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned address, illegal op, or bus error
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts the request
- bus_write  out  1  store flag
- bus_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 00)
- bus_wdata  out  DATA_W  lane-shifted store data
- bus_wstrb  out  4  byte strobes; 0000 for loads
- bus_resp_valid  in  1  bus response
- bus_resp_ready  out  1  high only in WAIT
- bus_rdata  in  DATA_W  full read word
- bus_err  in  1  bus error, qualified by bus_resp_valid

Behaviour:
- Reset: state=IDLE. All outputs are 0 except req_ready=1. Reset mid-transaction abandons the access; no response is produced. The bus side must tolerate a dropped request.
- States:
  - IDLE: req_ready=1. On req_valid, latch write, op, addr[1:0] and wdata.
    - If the access is legal, go to REQ.
    - If it is illegal, go to RESP with resp_err=1 and no bus traffic.
  - REQ: bus_req_valid=1. Address, data and strobes are held stable until bus_req_ready. On the handshake, go to WAIT.
  - WAIT: bus_resp_ready=1. On bus_resp_valid, capture the extended data and bus_err, then go to RESP.
  - RESP: resp_valid=1, with resp_rdata and resp_err held until resp_ready. On resp_ready, go to IDLE. No new request is accepted in the same cycle.
- Legality:
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00.
  - op 011, 110, 111 are illegal.
  - Stores with op[2]=1 are illegal.
- Stores:
  - sb: wstrb=0001<<addr[1:0]; wdata=replicate byte ×4.
  - sh: wstrb=0011<<addr[1:0]; wdata=replicate half ×2.
  - sw: wstrb=1111.
- Loads: select byte/half by the latched addr[1:0] from bus_rdata. Sign-extend for op[2]=0, zero-extend for op[2]=1.
- Minimum latency: req accept→resp_valid = 3 cycles when the bus responds immediately. Illegal access: resp_valid the cycle after accept.
- bus_resp_valid in the same cycle as the REQ handshake is not sampled; the response is taken in WAIT only.
- bus_err=1 forces resp_rdata=0 and resp_err=1.

Decomposition:
- Shared package holds mem_op encodings (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum.
- One sub-module, lsu_align: combinational store lane shift/strobe plus load extract/extend, reusable by a future cache.

Test Plan:
- sb, addr=0x8000_0003, wdata=0x0000_00AB → bus_wstrb=1000, bus_wdata=0xABAB_ABAB, bus_addr=0x8000_0000, resp_err=0.
- lh, addr=0x...2, bus_rdata=0x8001_1234 → resp_rdata=0xFFFF_8001; same with lhu → 0x0000_8001.
- lw, addr=0x...2 → no bus_req_valid ever, resp_valid the next cycle with resp_err=1, resp_rdata=0.
- lb, addr=0x...1, bus_rdata=0x0000_7F00; bus_req_ready delayed 3 cycles and resp_ready delayed 2 cycles → signals stable while stalled, resp_rdata=0x0000_007F, req_ready low until resp handshake.
- lw with bus_err=1 → resp_err=1, resp_rdata=0; then a clean sw completes normally.
- Assert rst while in WAIT → next cycle state IDLE, req_ready=1, resp_valid=0, bus_req_valid=0.
